// File: rtl/ooop_defs_pkg.sv
// Shared out-of-order pipeline definitions: physical/ROB tag widths and the
// per-lane commit record used by the commit stage.
package ooop_defs;

  localparam int PREG_W     = 7;
  localparam int ROB_TAG_W  = 4;
  localparam int ARCH_REG_W = 5;
  localparam int ARCH_REGS  = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_TAG_W-1:0]  tag;
    logic                  rd_used;
    logic [ARCH_REG_W-1:0] rd_arch;
    logic [PREG_W-1:0]     dest_new;
    logic [PREG_W-1:0]     dest_old;
  } commit_lane_t;

endpackage

// File: rtl/commit_unit_mw_free_tag_fifo.sv
// Multi-push (up to PUSH_W per cycle, packed in lane order), single-pop FIFO
// holding released physical tags on their way back to the freelist.
module free_tag_fifo #(
  parameter  int DEPTH  = 8,
  parameter  int PUSH_W = 2,
  parameter  int DATA_W = 7,
  localparam int AW     = $clog2(DEPTH),
  localparam int PTR_W  = AW + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PUSH_W-1:0]              push_valid,
  input  logic [PUSH_W-1:0][DATA_W-1:0]  push_data,
  input  logic                           pop,
  output logic                           head_valid,
  output logic [DATA_W-1:0]              head_data,
  output logic [PTR_W-1:0]               occupancy
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  push_cnt;
  logic [AW-1:0]     wr_addr [PUSH_W];

  // Sparse push lanes are compacted: each valid lane lands after the ones below it.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < PUSH_W; i++) begin
      // NOTE: blocking assignments here build a running sum across the loop; in
      // always_ff the same pattern would need <= and would not accumulate.
      wr_addr[i] = wr_ptr[AW-1:0] + push_cnt[AW-1:0];
      push_cnt   = push_cnt + PTR_W'(push_valid[i]);
    end
  end

  // NOTE: the storage array carries no reset; validity is tracked by the
  // pointers alone, which keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_W; i++) begin
      if (push_valid[i]) mem[wr_addr[i]] <= push_data[i];
    end
  end

  // Pointers carry one extra wrap bit: full = MSBs differ with equal low bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_cnt;
      rd_ptr <= rd_ptr + PTR_W'(pop);
    end
  end

  assign occupancy  = wr_ptr - rd_ptr;
  assign head_valid = (occupancy != '0);
  assign head_data  = head_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/commit_unit_mw.sv
// Multi-wide in-order commit: retires up to COMMIT_W ROB heads, updates the
// retirement RAT and queues old tags for the freelist. Define
// COMMIT_UNIT_STATS_EN to add retired/stall counters.
module commit_unit_mw #(
  parameter  int COMMIT_W    = 2,
  parameter  int FREEQ_DEPTH = 8,
  parameter  int ARCH_REGS   = ooop_defs::ARCH_REGS,
  parameter  int PREG_W      = ooop_defs::PREG_W,
  parameter  int ROB_TAG_W   = ooop_defs::ROB_TAG_W,
  localparam int CNT_W       = $clog2(COMMIT_W + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic [COMMIT_W-1:0]              rob_commit_valid_i,
  input  logic [COMMIT_W*ROB_TAG_W-1:0]    rob_commit_tag_i,
  input  logic [COMMIT_W-1:0]              rob_commit_rd_used_i,
  input  logic [COMMIT_W*5-1:0]            rob_commit_rd_arch_i,
  input  logic [COMMIT_W*PREG_W-1:0]       rob_commit_dest_new_i,
  input  logic [COMMIT_W*PREG_W-1:0]       rob_commit_dest_old_i,
  output logic [COMMIT_W-1:0]              commit_ready_o,
  output logic                             free_valid_o,
  output logic [PREG_W-1:0]                free_tag_o,
  input  logic                             free_ready_i,
  output logic [ARCH_REGS*PREG_W-1:0]      rrat_map_o,
  output logic [CNT_W-1:0]                 commit_count_o
`ifdef COMMIT_UNIT_STATS_EN
  ,
  output logic [31:0]                      stat_retired_o,
  output logic [31:0]                      stat_stall_o
`endif
);
  import ooop_defs::*;

  localparam int PTR_W = $clog2(FREEQ_DEPTH) + 1;

  commit_lane_t                        lane [COMMIT_W];
  logic [COMMIT_W-1:0]                 writes, retire, push_valid;
  logic [COMMIT_W-1:0][PREG_W-1:0]     push_data;
  logic [PTR_W-1:0]                    occupancy, free_slots, need_cnt;
  logic                                chain_ok;
  logic                                unused_tags;
  logic [PREG_W-1:0]                   rrat [ARCH_REGS];

  always_comb begin
    unused_tags = 1'b0;
    for (int i = 0; i < COMMIT_W; i++) begin
      lane[i].valid    = rob_commit_valid_i[i];
      lane[i].tag      = rob_commit_tag_i[i*ROB_TAG_W +: ROB_TAG_W];
      lane[i].rd_used  = rob_commit_rd_used_i[i];
      lane[i].rd_arch  = rob_commit_rd_arch_i[i*ARCH_REG_W +: ARCH_REG_W];
      lane[i].dest_new = rob_commit_dest_new_i[i*PREG_W +: PREG_W];
      lane[i].dest_old = rob_commit_dest_old_i[i*PREG_W +: PREG_W];
      writes[i]        = lane[i].valid && lane[i].rd_used && (lane[i].rd_arch != '0);
      unused_tags      = unused_tags ^ (^lane[i].tag);
    end
  end

  // Credit only slots free at cycle start; same-cycle pops are ignored.
  assign free_slots = PTR_W'(FREEQ_DEPTH) - occupancy;

  // Thermometer accept: any invalid lane or exhausted credit ends the group.
  always_comb begin
    commit_ready_o = '0;
    need_cnt       = '0;
    chain_ok       = !rst && !flush_i;
    for (int i = 0; i < COMMIT_W; i++) begin
      chain_ok = chain_ok && lane[i].valid;
      need_cnt = need_cnt + PTR_W'(writes[i]);
      if (need_cnt > free_slots) chain_ok = 1'b0;
      commit_ready_o[i] = chain_ok;
    end
  end

  always_comb begin
    commit_count_o = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      retire[i]      = rob_commit_valid_i[i] && commit_ready_o[i];
      push_valid[i]  = retire[i] && writes[i];
      push_data[i]   = lane[i].dest_old;
      commit_count_o = commit_count_o + CNT_W'(retire[i]);
    end
  end

  free_tag_fifo #(
    .DEPTH  (FREEQ_DEPTH),
    .PUSH_W (COMMIT_W),
    .DATA_W (PREG_W)
  ) u_free_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop        (free_valid_o && free_ready_i),
    .head_valid (free_valid_o),
    .head_data  (free_tag_o),
    .occupancy  (occupancy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ARCH_REGS; r++) rrat[r] <= PREG_W'(r);
    end else begin
      // NOTE: ascending lane order plus last-NBA-wins lets the youngest lane
      // own the entry when several lanes retire to the same rd.
      for (int i = 0; i < COMMIT_W; i++) begin
        if (push_valid[i]) rrat[lane[i].rd_arch] <= lane[i].dest_new;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ARCH_REGS; r++) rrat_map_o[r*PREG_W +: PREG_W] = rrat[r];
  end

`ifdef COMMIT_UNIT_STATS_EN
  logic        stall_cycle;
  logic [32:0] retired_sum;

  assign stall_cycle = rob_commit_valid_i[0] && !commit_ready_o[0] && !flush_i;
  assign retired_sum = {1'b0, stat_retired_o} + 33'(commit_count_o);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_retired_o <= '0;
      stat_stall_o   <= '0;
    end else begin
      stat_retired_o <= retired_sum[32] ? '1 : retired_sum[31:0];
      if (stall_cycle && (stat_stall_o != '1)) stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_unit_mw.sv
// Scoreboard bench for commit_unit_mw: directed commit groups, expected freed
// tags queued at issue and popped by an independent free-port monitor.
module tb_commit_unit_mw;

  localparam int CW = 2;
  localparam int PW = 7;
  localparam int TW = 4;
  localparam int AR = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic [CW-1:0]     valid, used, ready;
  logic [CW*TW-1:0]  tag;
  logic [CW*5-1:0]   rd;
  logic [CW*PW-1:0]  dnew, dold;
  logic              free_valid, free_ready;
  logic [PW-1:0]     free_tag;
  logic [AR*PW-1:0]  rrat;
  logic [1:0]        count;
`ifdef COMMIT_UNIT_STATS_EN
  logic [31:0]       stat_retired, stat_stall;
`endif

  commit_unit_mw #(.COMMIT_W(CW), .FREEQ_DEPTH(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush_i               (flush_i),
    .rob_commit_valid_i    (valid),
    .rob_commit_tag_i      (tag),
    .rob_commit_rd_used_i  (used),
    .rob_commit_rd_arch_i  (rd),
    .rob_commit_dest_new_i (dnew),
    .rob_commit_dest_old_i (dold),
    .commit_ready_o        (ready),
    .free_valid_o          (free_valid),
    .free_tag_o            (free_tag),
    .free_ready_i          (free_ready),
    .rrat_map_o            (rrat),
    .commit_count_o        (count)
`ifdef COMMIT_UNIT_STATS_EN
    ,
    .stat_retired_o        (stat_retired),
    .stat_stall_o          (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_retired = 0;
  int exp_stall = 0;
  int mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rrat_of(input int r);
    return rrat[r*PW +: PW];
  endfunction

  task automatic set_lane(input int i, input bit v, input bit u, input int r, input int nw, input int od);
    valid[i]          = v;
    used[i]           = u;
    rd[i*5 +: 5]      = 5'(r);
    dnew[i*PW +: PW]  = PW'(nw);
    dold[i*PW +: PW]  = PW'(od);
    tag[i*TW +: TW]   = TW'(i);
  endtask

  task automatic idle_lanes();
    valid = '0;
    used  = '0;
  endtask

  // Present the current lane vector for one cycle and check the accept response.
  task automatic step(input string name, input logic [1:0] exp_ready, input int exp_cnt);
    @(negedge clk);
    check({name, " ready"}, 64'(ready), 64'(exp_ready));
    check({name, " count"}, 64'(count), 64'(exp_cnt));
`ifdef COMMIT_UNIT_STATS_EN
    check({name, " stat_retired"}, 64'(stat_retired), 64'(exp_retired));
    check({name, " stat_stall"}, 64'(stat_stall), 64'(exp_stall));
`endif
    exp_retired += exp_cnt;
    if (valid[0] && !exp_ready[0] && !flush_i) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int budget = 30;
    do begin
      @(posedge clk);
      budget--;
    end while (exp_q.size() != 0 && budget > 0);
    #1;
    check({name, " drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Free-port monitor: every handshake must match the oldest expected tag.
  always @(negedge clk) begin
    if (!rst && free_valid && free_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL free_tag unexpected: got %0d expected none", free_tag);
      end else begin
        mon_exp = exp_q.pop_front();
        check("free_tag", 64'(free_tag), 64'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; free_ready = 1'b1;
    set_lane(0, 1, 1, 3, 40, 3);
    set_lane(1, 1, 1, 7, 41, 7);

    // Reset state with valid lanes presented.
    @(negedge clk);
    check("rst ready", 64'(ready), 64'd0);
    check("rst count", 64'(count), 64'd0);
    check("rst free_valid", 64'(free_valid), 64'd0);
    check("rst free_tag", 64'(free_tag), 64'd0);
    check("rst rrat5", 64'(rrat_of(5)), 64'd5);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two independent destinations.
    step("two_rd", 2'b11, 2);
    exp_q.push_back(3); exp_q.push_back(7);
    idle_lanes();
    check("rrat3", 64'(rrat_of(3)), 64'd40);
    check("rrat7", 64'(rrat_of(7)), 64'd41);
    drain("two_rd");

    // Same destination on both lanes: youngest wins, both olds freed.
    set_lane(0, 1, 1, 9, 50, 9);
    set_lane(1, 1, 1, 9, 51, 50);
    step("same_rd", 2'b11, 2);
    exp_q.push_back(9); exp_q.push_back(50);
    idle_lanes();
    check("rrat9", 64'(rrat_of(9)), 64'd51);
    drain("same_rd");

    // Fill the FIFO with the freelist stalled.
    free_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 1, 1, 20 + 2*k, 110 + 2*k, 60 + 2*k);
      set_lane(1, 1, 1, 21 + 2*k, 111 + 2*k, 61 + 2*k);
      step("fill", 2'b11, 2);
      exp_q.push_back(60 + 2*k); exp_q.push_back(61 + 2*k);
    end
    set_lane(0, 1, 1, 1, 70, 66);
    set_lane(1, 0, 0, 0, 0, 0);
    step("fill7", 2'b01, 1);
    exp_q.push_back(66);
    set_lane(0, 1, 1, 2, 71, 67);
    set_lane(1, 1, 1, 4, 72, 68);
    step("one_slot", 2'b01, 1);
    exp_q.push_back(67);
    set_lane(0, 1, 1, 4, 72, 68);
    set_lane(1, 1, 1, 5, 73, 69);
    step("full_a", 2'b00, 0);
    step("full_b", 2'b00, 0);
    idle_lanes();
    check("rrat2", 64'(rrat_of(2)), 64'd71);
    check("rrat4 kept", 64'(rrat_of(4)), 64'd4);
    check("full free_valid", 64'(free_valid), 64'd1);
    free_ready = 1'b1;
    drain("fill");

    // Flush with tags queued: no commits, queue survives.
    free_ready = 1'b0;
    set_lane(0, 1, 1, 10, 80, 10);
    set_lane(1, 1, 1, 11, 81, 11);
    step("pre_flush2", 2'b11, 2);
    exp_q.push_back(10); exp_q.push_back(11);
    set_lane(0, 1, 1, 12, 82, 12);
    set_lane(1, 0, 0, 0, 0, 0);
    step("pre_flush1", 2'b01, 1);
    exp_q.push_back(12);
    flush_i = 1'b1;
    set_lane(0, 1, 1, 13, 90, 13);
    set_lane(1, 1, 1, 14, 91, 14);
    step("flush", 2'b00, 0);
    flush_i = 1'b0;
    idle_lanes();
    check("flush free_valid", 64'(free_valid), 64'd1);
    check("rrat12", 64'(rrat_of(12)), 64'd82);
    check("rrat13 kept", 64'(rrat_of(13)), 64'd13);
    check("rrat14 kept", 64'(rrat_of(14)), 64'd14);
    free_ready = 1'b1;
    drain("flush");

    // x0 and no-rd lanes retire without pushes or RRAT writes.
    set_lane(0, 1, 1, 0, 95, 0);
    set_lane(1, 1, 0, 6, 96, 6);
    step("no_rd", 2'b11, 2);
    idle_lanes();
    check("no_rd free_valid", 64'(free_valid), 64'd0);
    check("rrat0", 64'(rrat_of(0)), 64'd0);
    check("rrat6", 64'(rrat_of(6)), 64'd6);

    // Asynchronous reset in the middle of a drain.
    free_ready = 1'b0;
    set_lane(0, 1, 1, 3, 100, 40);
    set_lane(1, 1, 1, 5, 101, 5);
    step("pre_rst", 2'b11, 2);
    exp_q.push_back(40); exp_q.push_back(5);
    free_ready = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_retired = 0;
    exp_stall = 0;
    #1;
    check("mid_rst ready", 64'(ready), 64'd0);
    check("mid_rst free_valid", 64'(free_valid), 64'd0);
    check("mid_rst free_tag", 64'(free_tag), 64'd0);
    check("mid_rst rrat3", 64'(rrat_of(3)), 64'd3);
    check("mid_rst rrat5", 64'(rrat_of(5)), 64'd5);
    idle_lanes();
    @(posedge clk); #1;
    rst = 1'b0;
    set_lane(0, 1, 1, 8, 120, 8);
    set_lane(1, 0, 0, 0, 0, 0);
    step("post_rst", 2'b01, 1);
    exp_q.push_back(8);
    idle_lanes();
    check("post_rst rrat8", 64'(rrat_of(8)), 64'd120);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/commit_unit_mw.md
Name: commit_unit_mw

Overview:
- Parametrised multi-wide successor to the single-lane commit stage.
- Retires up to COMMIT_W in-order ROB heads per cycle.
- Maintains the retirement RAT (architectural-to-physical map) used for flush recovery.
- Buffers released old physical tags in a FIFO that drains one tag per cycle to the freelist. Back-pressure reaches the ROB when the FIFO cannot absorb a commit group.

Parameters:
- COMMIT_W, 2, commit lanes per cycle (1..4).
- FREEQ_DEPTH, 8, free-tag FIFO entries (power of 2, ≥ COMMIT_W).
- ARCH_REGS, 32, architectural registers; x0 is never remapped.
- PREG_W, 7, physical tag width; the value equals the package constant.
- ROB_TAG_W, 4, ROB tag width; the value equals the package constant.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush_i  in  1  pipeline flush; blocks commit this cycle.
- rob_commit_valid_i  in  COMMIT_W  per-lane head valid; lane 0 is the oldest.
- rob_commit_tag_i  in  COMMIT_W*ROB_TAG_W  per-lane ROB tag.
- rob_commit_rd_used_i  in  COMMIT_W  lane writes rd.
- rob_commit_rd_arch_i  in  COMMIT_W*5  architectural rd.
- rob_commit_dest_new_i  in  COMMIT_W*PREG_W  new physical tag.
- rob_commit_dest_old_i  in  COMMIT_W*PREG_W  previous physical tag.
- commit_ready_o  out  COMMIT_W  per-lane accept (thermometer).
- free_valid_o  out  1  FIFO head valid to freelist.
- free_tag_o  out  PREG_W  FIFO head tag.
- free_ready_i  in  1  freelist accepts head.
- rrat_map_o  out  ARCH_REGS*PREG_W  retirement RAT contents, registered.
- commit_count_o  out  $clog2(COMMIT_W+1)  lanes retired this cycle (comb).

Behaviour:
- Lane i retires when valid[i] && ready[i].
- ready[i] = !flush_i && valid[0..i] all 1 && ready[i-1] && (count of rd_used&&rd_arch≠0 over lanes 0..i) ≤ free slots. Result is thermometer; a gap in valid ends the group.
- Free slots = FREEQ_DEPTH − occupancy at cycle start. Same-cycle pops are not credited; this is conservative by design.
- Retiring lane with rd_used && rd_arch≠0:
  - writes rrat[rd_arch] ← dest_new, visible on rrat_map_o next cycle;
  - pushes dest_old to the FIFO.
- Lanes with rd_arch=0 or !rd_used push nothing and write nothing.
- Multiple retiring lanes targeting the same rd_arch: the highest lane wins the RRAT write. All of their dest_old tags are still pushed.
- FIFO pushes occur in lane order. Up to COMMIT_W pushes and 1 pop per cycle.
- Pop when free_valid_o && free_ready_i. free_valid_o = occupancy≠0; free_tag_o = head, stable while stalled.
- Pointers are $clog2(FREEQ_DEPTH)+1 bits and wrap modulo 2·DEPTH. Full = MSB differ, low bits equal. Overflow is impossible by construction; underflow is impossible since pop requires valid.
- flush_i:
  - no commits this cycle; all ready bits 0;
  - the FIFO is NOT cleared, because tags already queued belong to retired instructions;
  - the RRAT is unchanged.
- Reset (async, any cycle, including mid-drain):
  - rrat[i] ← i for i<ARCH_REGS;
  - FIFO empty, free_valid_o=0, free_tag_o=0;
  - commit_ready_o=0 while rst is asserted.
- commit_count_o = popcount of retiring lanes; 0 during reset/flush.

Optional Feature:
- Macro: COMMIT_UNIT_STATS_EN.
- With macro:
  - 32-bit output stat_retired_o, cumulative lanes retired;
  - 32-bit output stat_stall_o, cycles where valid[0]=1 but ready[0]=0 and !flush_i.
  - Both counters saturate at 2^32−1 and reset to 0.
- Without macro: ports and counters are absent; all other behaviour is identical.

Decomposition:
- ooop_defs package holds PREG_W, ROB_TAG_W, ARCH_REG_W=5, ARCH_REGS and commit_lane_t (valid, tag, rd_used, rd_arch, dest_new, dest_old).
- One sub-module: free_tag_fifo. It is a multi-push (≤COMMIT_W), single-pop FIFO with occupancy output, parametrised by DEPTH, PUSH_W and data width.
- RRAT and ready logic live in the top module.

Test Plan:
- Reset, then inspect → rrat_map_o[5]=5, free_valid_o=0, and ready=2'b00 while rst is high.
- Lane0 {rd_used, rd=3, new=40, old=3}, lane1 {rd_used, rd=7, new=41, old=7}, free_ready=1 → ready=2'b11, commit_count=2. Next cycle rrat[3]=40, rrat[7]=41; FIFO emits 3 then 7 on consecutive cycles.
- Both lanes rd=9 (new 50/51, old 9/50) → rrat[9]=51; FIFO emits 9 then 50.
- free_ready=0, DEPTH=8, fill to 7 entries, two rd lanes valid → ready=2'b01, one push. Occupancy 8 → ready=2'b00 and the stall counter increments (STATS_EN build).
- flush_i=1 with 3 queued tags and both lanes valid → ready=0 and RRAT unchanged; the 3 tags still drain after the flush.
- Lane0 rd=0 with rd_used, lane1 !rd_used → both retire, no push, RRAT unchanged, commit_count=2.
